spi_slave: RTL and testbench

- 8-bit SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, oversampled in the system `clk` domain.
- Receives a byte on `mosi` and presents it on `data_out`; transmits the byte held on `data_in` over `miso`.
- Sits between an external SPI master and local register/FIFO logic clocked by `clk`.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_slave.sv | 90 +++++++++
 tb/tb_spi_slave.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI slave block.
package spi_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH);

    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses on the synchronized value.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] q;
    logic              prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= {STAGES{IDLE}};
            prev <= IDLE;
        end else begin
            q    <= {q[STAGES-2:0], din};
            prev <= q[STAGES-1];
        end
    end

    assign sync = q[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave, MSB first, oversampled in the clk domain.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             done
);
    localparam int CW = cnt_bits(WIDTH);

    logic                   sclk_s, sclk_rise, sclk_fall;
    logic                   cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;
    logic [SYNC_STAGES-1:0] settle;
    logic                   settled, armed, active, start, last;
    logic [CW-1:0]          cnt;
    logic [WIDTH-2:0]       rx, tx;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(cs), .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    // sclk level itself is only needed through its edges
    logic sclk_level_unused;
    assign sclk_level_unused = sclk_s;

    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign settled = settle[SYNC_STAGES-1];
    // A frame may only start once cs has been seen high after reset, so a cs
    // already low at reset release cannot open a frame until it toggles.
    assign active  = armed & ~cs_s;
    assign start   = armed & cs_fall;
    assign last    = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_q   <= '0;
            settle   <= '0;
            armed    <= 1'b0;
            cnt      <= '0;
            rx       <= '0;
            tx       <= '0;
            miso     <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            armed  <= armed | (settled & cs_s);
            done   <= 1'b0;
            if (cs_rise)
                rx <= '0;
            if (start) begin
                cnt  <= '0;
                tx   <= data_in[WIDTH-2:0];
                miso <= data_in[WIDTH-1];
            end else if (!active) begin
                cnt  <= '0;
                miso <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx  <= {rx[WIDTH-3:0], mosi_s};
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        data_out <= {rx, mosi_s};
                        done     <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    tx   <= (cnt == '0) ? data_in[WIDTH-2:0] : {tx[WIDTH-3:0], 1'b0};
                    miso <= (cnt == '0) ? data_in[WIDTH-1] : tx[WIDTH-2];
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of the SPI slave with a behavioural mode-0 master.
module tb_spi_slave;
    logic       clk = 1'b0;
    logic       rst, sclk, cs, mosi, miso, done;
    logic [7:0] data_in, data_out;
    logic [7:0] got;
    int         total = 0;
    int         passes = 0;
    int         done_cnt = 0;
    time        rise_t = 0;
    time        done_t = 0;

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .data_in(data_in), .data_out(data_out), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_t = $time;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Master drives mosi with sclk rising and samples miso at that instant.
    task automatic xfer(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mosi = b[i];
            sclk = 1'b1;
            got[i] = miso;
            rise_t = $time;
            #40;
            sclk = 1'b0;
            #40;
        end
    endtask

    task automatic frame(input logic [7:0] b);
        cs = 1'b0;
        #40;
        got = '0;
        xfer(b, 7, 0);
        cs = 1'b1;
        #80;
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; sclk = 1'b1; mosi = 1'b1; data_in = 8'hFF; got = '0;
        #40;
        check("rst_data_out", 32'(data_out), 'h00);
        check("rst_miso", 32'(miso), 0);
        check("rst_done", 32'(done), 0);
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #20;
        rst = 1'b1;
        #100;
        check("rel_data_out", 32'(data_out), 'h00);
        check("rel_miso", 32'(miso), 0);
        check("rel_done", 32'(done), 0);

        data_in = 8'h5A;
        cs = 1'b0;
        #40;
        got = '0;
        xfer(8'h5A, 7, 0);
        check("basic_data_out", 32'(data_out), 'h5A);
        check("basic_miso", 32'(got), 'h5A);
        check("basic_done_cnt", 32'(done_cnt), 1);
        check("basic_done_latency", 32'(done_t - rise_t), 30);
        cs = 1'b1;
        #80;
        check("cs_high_miso", 32'(miso), 0);

        data_in = 8'hA5;
        frame(8'h3C);
        check("tx_miso", 32'(got), 'hA5);
        check("tx_data_out", 32'(data_out), 'h3C);
        check("tx_done_cnt", 32'(done_cnt), 2);

        data_in = 8'h18;
        cs = 1'b0;
        #40;
        got = '0;
        xfer(8'h81, 7, 4);
        data_in = 8'hC3;
        xfer(8'h81, 3, 0);
        check("b2b_byte1_data_out", 32'(data_out), 'h81);
        check("b2b_byte1_miso", 32'(got), 'h18);
        check("b2b_byte1_done_cnt", 32'(done_cnt), 3);
        got = '0;
        xfer(8'h7E, 7, 0);
        check("b2b_byte2_data_out", 32'(data_out), 'h7E);
        check("b2b_byte2_miso", 32'(got), 'hC3);
        check("b2b_byte2_done_cnt", 32'(done_cnt), 4);
        cs = 1'b1;
        #80;

        data_in = 8'h00;
        frame(8'h5A);
        check("pre_abort_data_out", 32'(data_out), 'h5A);
        cs = 1'b0;
        #40;
        xfer(8'hFF, 7, 3);
        cs = 1'b1;
        #80;
        check("abort_data_out", 32'(data_out), 'h5A);
        check("abort_done_cnt", 32'(done_cnt), 5);
        frame(8'h12);
        check("post_abort_data_out", 32'(data_out), 'h12);
        check("post_abort_done_cnt", 32'(done_cnt), 6);

        data_in = 8'h66;
        cs = 1'b0;
        #40;
        xfer(8'hF0, 7, 4);
        rst = 1'b0;
        #20;
        check("midrst_data_out", 32'(data_out), 'h00);
        check("midrst_miso", 32'(miso), 0);
        check("midrst_done", 32'(done), 0);
        rst = 1'b1;
        #40;
        xfer(8'hFF, 7, 0);
        check("cs_low_at_release_data_out", 32'(data_out), 'h00);
        check("cs_low_at_release_done_cnt", 32'(done_cnt), 6);
        cs = 1'b1;
        #80;
        data_in = 8'hE7;
        frame(8'h99);
        check("after_rst_data_out", 32'(data_out), 'h99);
        check("after_rst_miso", 32'(got), 'hE7);
        check("after_rst_done_cnt", 32'(done_cnt), 7);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
